// File: rtl/axi_r_alloc_pkg.sv
// rtl/axi_r_alloc_pkg.sv - shared types and default widths for the R-channel response allocator
package axi_r_alloc_pkg;
    localparam int N_TARG_PORT_DEF = 8;
    localparam int AXI_ID_IN_DEF   = 16;
    localparam int AXI_DATA_W_DEF  = 64;
    localparam int AXI_USER_W_DEF  = 6;
    localparam int ROUTE_W         = $clog2(N_TARG_PORT_DEF);

    typedef enum logic {IDLE, LOCKED} r_alloc_state_e;

    typedef struct packed {
        logic [AXI_ID_IN_DEF-1:0]  id;
        logic [AXI_DATA_W_DEF-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [AXI_USER_W_DEF-1:0] user;
    } r_beat_t;
endpackage

// File: rtl/axi_r_alloc_rr_arb.sv
// rtl/axi_r_alloc_rr_arb.sv - rotating-priority find-first: first set req at or after ptr, wrapping
module axi_r_alloc_rr_arb #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);
    int j;

    // Scan from the farthest offset down so the nearest request is written last and wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            if (req[j]) begin
                idx   = W'(j);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_response_allocator_r.sv
// rtl/axi_response_allocator_r.sv - merges N R streams with burst-locked round robin; AXI_R_ALLOC_OUT_REG_EN adds output skid buffer
module axi_response_allocator_r
    import axi_r_alloc_pkg::*;
#(
    parameter int N_TARG_PORT = N_TARG_PORT_DEF,
    parameter int AXI_ID_IN   = AXI_ID_IN_DEF,
    parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
    parameter int AXI_DATA_W  = AXI_DATA_W_DEF,
    parameter int AXI_USER_W  = AXI_USER_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXI_ID_OUT-1:0]  rid_i   [N_TARG_PORT],
    input  logic [AXI_DATA_W-1:0]  rdata_i [N_TARG_PORT],
    input  logic [1:0]             rresp_i [N_TARG_PORT],
    input  logic [N_TARG_PORT-1:0] rlast_i,
    input  logic [AXI_USER_W-1:0]  ruser_i [N_TARG_PORT],
    input  logic [N_TARG_PORT-1:0] rvalid_i,
    output logic [N_TARG_PORT-1:0] rready_o,
    output logic [AXI_ID_IN-1:0]   rid_o,
    output logic [AXI_DATA_W-1:0]  rdata_o,
    output logic [1:0]             rresp_o,
    output logic                   rlast_o,
    output logic [AXI_USER_W-1:0]  ruser_o,
    output logic                   rvalid_o,
    input  logic                   rready_i
);
    localparam int SEL_W = $clog2(N_TARG_PORT);

    typedef struct packed {
        logic [AXI_ID_IN-1:0]  id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } beat_t;

    r_alloc_state_e   state;
    logic [SEL_W-1:0] rr_ptr, lock_idx, arb_idx, g;
    logic             hold, arb_vld, gv, out_ready, hs;
    beat_t            g_beat, out_beat;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        return (int'(i) == N_TARG_PORT - 1) ? '0 : i + 1'b1;
    endfunction

    axi_r_alloc_rr_arb #(.N(N_TARG_PORT), .W(SEL_W)) u_arb (
        .req   (rvalid_i),
        .ptr   (rr_ptr),
        .idx   (arb_idx),
        .valid (arb_vld)
    );

    // lock_idx doubles as the pending index while an IDLE grant waits for ready.
    always_comb begin
        g  = (state == LOCKED || hold) ? lock_idx : arb_idx;
        gv = 1'b0;
        if (!rst) gv = (state == LOCKED || hold) ? rvalid_i[g] : arb_vld;
        g_beat.id   = rid_i[g][AXI_ID_IN-1:0];
        g_beat.data = rdata_i[g];
        g_beat.resp = rresp_i[g];
        g_beat.last = rlast_i[g];
        g_beat.user = ruser_i[g];
        hs          = gv & out_ready;
        rready_o    = '0;
        rready_o[g] = hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            hold     <= 1'b0;
        end else if (hs) begin
            hold <= 1'b0;
            if (g_beat.last) begin
                state  <= IDLE;
                rr_ptr <= next_idx(g);
            end else begin
                state    <= LOCKED;
                lock_idx <= g;
            end
        end else if (gv && state == IDLE) begin
            hold     <= 1'b1;
            lock_idx <= g;
        end
    end

`ifdef AXI_R_ALLOC_OUT_REG_EN
    beat_t      sb_mem [2];
    logic [1:0] sb_cnt;
    logic       sb_head, sb_pop;

    assign out_ready = (sb_cnt != 2'd2);
    assign rvalid_o  = (sb_cnt != 2'd0);
    assign sb_pop    = rvalid_o & rready_i;
    assign out_beat  = rvalid_o ? sb_mem[sb_head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_cnt  <= '0;
            sb_head <= 1'b0;
        end else begin
            if (hs) sb_mem[sb_head ^ sb_cnt[0]] <= g_beat;
            if (sb_pop) sb_head <= ~sb_head;
            sb_cnt <= sb_cnt + {1'b0, hs} - {1'b0, sb_pop};
        end
    end
`else
    assign out_ready = rready_i;
    assign rvalid_o  = gv;
    assign out_beat  = gv ? g_beat : '0;
`endif

    assign rid_o   = out_beat.id;
    assign rdata_o = out_beat.data;
    assign rresp_o = out_beat.resp;
    assign rlast_o = out_beat.last;
    assign ruser_o = out_beat.user;
endmodule

// File: tb/tb_axi_response_allocator_r.sv
// tb/tb_axi_response_allocator_r.sv - scoreboard bench for the R-channel response allocator
module tb_axi_response_allocator_r;
    localparam int N = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [18:0]       rid_i   [N];
    logic [63:0]       rdata_i [N];
    logic [1:0]        rresp_i [N];
    logic [N-1:0]      rlast_i = '0;
    logic [5:0]        ruser_i [N];
    logic [N-1:0]      rvalid_i = '0;
    logic [N-1:0]      rready_o;
    logic [15:0]       rid_o;
    logic [63:0]       rdata_o;
    logic [1:0]        rresp_o;
    logic              rlast_o;
    logic [5:0]        ruser_o;
    logic              rvalid_o;
    logic              rready_i = 1'b1;

    axi_response_allocator_r dut (
        .clk(clk), .rst(rst), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .ruser_i(ruser_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .ruser_o(ruser_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit last; int tag; } sbeat_t;
    typedef struct { int s; int tag; bit last; } exp_t;

    sbeat_t src_q [N][$];
    exp_t   exp_q [$];
    logic [N-1:0] hs_snap = '0;
    logic [N-1:0] shown_gap = '0;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [15:0] mk_id(input int s, input int tag);
        return {4'(s), 12'(tag)};
    endfunction

    function automatic logic [63:0] mk_data(input int s, input int tag);
        return {8'(s), 24'h00c0de, 32'(tag)};
    endfunction

    function automatic logic [127:0] mk_beat(input int s, input int tag, input bit last);
        return 128'({mk_id(s, tag), mk_data(s, tag), 2'(s), last, 6'(tag)});
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic src_beat(input int s, input int tag, input bit last);
        sbeat_t b;
        b.v = 1'b1; b.last = last; b.tag = tag;
        src_q[s].push_back(b);
    endtask

    task automatic src_gap(input int s);
        sbeat_t b;
        b.v = 1'b0; b.last = 1'b0; b.tag = 0;
        src_q[s].push_back(b);
    endtask

    task automatic exp_beat(input int s, input int tag, input bit last);
        exp_t e;
        e.s = s; e.tag = tag; e.last = last;
        exp_q.push_back(e);
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return exp_q.size() == 0;
    endfunction

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk); #2;
            n++;
            if (all_idle()) break;
        end
        if (!all_idle()) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, %0d expected beats still outstanding", name, exp_q.size());
        end
    endtask

    // Source models: advance after a sampled handshake or after showing a one-cycle gap.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 && (hs_snap[i] || shown_gap[i])) void'(src_q[i].pop_front());
            if (src_q[i].size() != 0) begin
                rvalid_i[i]  = src_q[i][0].v;
                rlast_i[i]   = src_q[i][0].last;
                rid_i[i]     = {3'(i), mk_id(i, src_q[i][0].tag)};
                rdata_i[i]   = mk_data(i, src_q[i][0].tag);
                rresp_i[i]   = 2'(i);
                ruser_i[i]   = 6'(src_q[i][0].tag);
                shown_gap[i] = !src_q[i][0].v;
            end else begin
                rvalid_i[i]  = 1'b0;
                rlast_i[i]   = 1'b0;
                rid_i[i]     = '0;
                rdata_i[i]   = '0;
                rresp_i[i]   = '0;
                ruser_i[i]   = '0;
                shown_gap[i] = 1'b0;
            end
        end
    end

    // Monitor: every merged handshake pops one expected beat.
    always @(negedge clk) begin
        exp_t e;
        hs_snap = rvalid_i & rready_o;
        if (!rst && rvalid_o && rready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got id %h data %h want none", rid_o, rdata_o);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("beat_src%0d_tag%0h", e.s, e.tag),
                      128'({rid_o, rdata_o, rresp_o, rlast_o, ruser_o}),
                      mk_beat(e.s, e.tag, e.last));
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            rid_i[i] = '0; rdata_i[i] = '0; rresp_i[i] = '0; ruser_i[i] = '0;
        end

        // Reset with all sources valid; afterwards they drain in index order from rr_ptr=0.
        for (int i = 0; i < N; i++) begin
            src_beat(i, 16'h10 + i, 1'b1);
            exp_beat(i, 16'h10 + i, 1'b1);
        end
        repeat (2) begin
            @(negedge clk);
            check("reset_rvalid_o", 128'(rvalid_o), 128'(0));
            check("reset_rready_o", 128'(rready_o), 128'(0));
        end
        @(posedge clk); #2;
        rst = 1'b0;
        wait_idle("reset_drain", n);
        @(negedge clk);
        check("idle_outputs_zero", 128'({rvalid_o, rid_o, rdata_o}), 128'(0));

        // Round robin over 0,3,5 then 0 again, one beat per cycle.
        @(posedge clk); #2;
        src_beat(0, 16'h20, 1'b1); src_beat(3, 16'h21, 1'b1);
        src_beat(5, 16'h22, 1'b1); src_beat(0, 16'h23, 1'b1);
        exp_beat(0, 16'h20, 1'b1); exp_beat(3, 16'h21, 1'b1);
        exp_beat(5, 16'h22, 1'b1); exp_beat(0, 16'h23, 1'b1);
        wait_idle("round_robin", n);
        check("round_robin_cycles_le5", 128'(n <= 5), 128'(1));

        // src2 4-beat burst with src6 waiting: burst completes before src6.
        @(posedge clk); #2;
        for (int b = 0; b < 4; b++) src_beat(2, 16'h30 + b, b == 3);
        src_beat(6, 16'h34, 1'b1);
        for (int b = 0; b < 4; b++) exp_beat(2, 16'h30 + b, b == 3);
        exp_beat(6, 16'h34, 1'b1);
        wait_idle("burst_lock", n);
        check("burst_cycles_le6", 128'(n <= 6), 128'(1));

        // Backpressure: beat from src1 held stable for 5 cycles.
        @(posedge clk); #2;
        rready_i = 1'b0;
        src_beat(1, 16'h40, 1'b1);
        exp_beat(1, 16'h40, 1'b1);
        repeat (2) @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rvalid_o", 128'(rvalid_o), 128'(1));
            check("bp_payload", 128'({rid_o, rdata_o}), 128'({mk_id(1, 16'h40), mk_data(1, 16'h40)}));
`ifndef AXI_R_ALLOC_OUT_REG_EN
            check("bp_rready_o", 128'(rready_o), 128'(0));
`endif
        end
        @(posedge clk); #2;
        rready_i = 1'b1;
        wait_idle("backpressure", n);

        // Mid-burst bubble on src4 must not let src0 in.
        @(posedge clk); #2;
        src_beat(4, 16'h50, 1'b0); src_beat(4, 16'h51, 1'b0);
        src_gap(4); src_gap(4); src_gap(4);
        src_beat(4, 16'h52, 1'b1);
        src_beat(0, 16'h53, 1'b1);
        exp_beat(4, 16'h50, 1'b0); exp_beat(4, 16'h51, 1'b0);
        exp_beat(4, 16'h52, 1'b1); exp_beat(0, 16'h53, 1'b1);
        wait_idle("bubble", n);

        // Move rr_ptr to 7, then 7 and 0 compete: 7 first.
        @(posedge clk); #2;
        src_beat(6, 16'h60, 1'b1);
        exp_beat(6, 16'h60, 1'b1);
        wait_idle("wrap_setup", n);
        @(posedge clk); #2;
        src_beat(7, 16'h61, 1'b1); src_beat(0, 16'h62, 1'b1);
        exp_beat(7, 16'h61, 1'b1); exp_beat(0, 16'h62, 1'b1);
        wait_idle("wrap", n);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
